hnf_rxreq_ingress: RTL and testbench

// - Parametrised CHI RXREQ link-layer receiver for the HN-F.
// - Grants L-credits, accepts REQ flits into a POCQ of DEPTH entries and checks TgtID.
// - Presents queued flits to the HN-F request pipeline over a valid/ready interface.
// - Adds credit accounting, link deactivation, misdirected-flit drop and sticky error reporting.

---
 rtl/hnf_rxreq_ingress.sv | 138 +++++++++++++
 tb/tb_hnf_rxreq_ingress.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hnf_rxreq_ingress.sv
// hnf_rxreq_ingress: CHI RXREQ link-layer receiver for the HN-F.
// Grants L-credits, drops misdirected or uncredited flits and queues the rest in the POCQ.
module hnf_rxreq_ingress #(
    parameter int FLIT_W      = 64,
    parameter int DEPTH       = 8,
    parameter int MAX_CREDITS = 15,
    parameter int TGTID_LSB   = 4,
    parameter int TGTID_W     = 7,
    parameter int HN_ID       = 0
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       link_en,
    input  logic                       rxreqflitpend,
    input  logic                       rxreqflitv,
    input  logic [FLIT_W-1:0]          rxreqflit,
    output logic                       rxreqlcrdv,
    output logic [FLIT_W-1:0]          out_flit,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [3:0]                 credits_out,
    output logic                       link_idle,
    input  logic                       err_clr,
    output logic                       err_overflow,
    output logic                       err_pend,
    output logic                       err_tgtid,
    output logic [7:0]                 tgtid_err_cnt
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = ((OCC_W > 4) ? OCC_W : 4) + 1;

    localparam logic [SUM_W-1:0]   MAX_C    = SUM_W'(MAX_CREDITS);
    localparam logic [SUM_W-1:0]   DEPTH_C  = SUM_W'(DEPTH);
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [TGTID_W-1:0] MY_ID    = TGTID_W'(HN_ID);

    logic [FLIT_W-1:0] pocq [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pend_q;

    logic              consume;
    logic              overflow;
    logic              tgt_ok;
    logic              enq;
    logic              tgt_bad;
    logic              pop;
    logic              pend_miss;
    logic              grant;
    logic [SUM_W-1:0]  credits_after;
    logic [SUM_W-1:0]  occ_after;

    assign consume   = rxreqflitv && (credits_out != 4'd0);
    assign overflow  = rxreqflitv && (credits_out == 4'd0);
    assign tgt_ok    = (rxreqflit[TGTID_LSB +: TGTID_W] == MY_ID);
    assign enq       = consume && tgt_ok;
    assign tgt_bad   = consume && !tgt_ok;
    assign pop       = out_valid && out_ready;
    assign pend_miss = rxreqflitv && !pend_q;

    assign out_valid = (occupancy != '0);
    assign out_flit  = out_valid ? pocq[rd_ptr] : '0;
    assign link_idle = !link_en && (credits_out == 4'd0);

    // The grant sees this cycle's consume and pop, so freed budget is re-granted without a bubble.
    always_comb begin
        credits_after = SUM_W'(credits_out) - SUM_W'(consume);
        occ_after     = SUM_W'(occupancy) + SUM_W'(enq) - SUM_W'(pop);
        grant         = link_en && (credits_after < MAX_C) &&
                        ((credits_after + occ_after) < DEPTH_C);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            credits_out <= 4'd0;
            rxreqlcrdv  <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            credits_out <= 4'(credits_after + SUM_W'(grant));
            rxreqlcrdv  <= grant;
            pend_q      <= rxreqflitpend;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            occupancy <= OCC_W'(occ_after);
        end
    end

    // Storage needs no reset: out_flit is masked while the queue is empty.
    always_ff @(posedge clock) begin
        if (enq) begin
            pocq[wr_ptr] <= rxreqflit;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow  <= 1'b0;
            err_pend      <= 1'b0;
            err_tgtid     <= 1'b0;
            tgtid_err_cnt <= 8'd0;
        end else if (err_clr) begin
            err_overflow  <= 1'b0;
            err_pend      <= 1'b0;
            err_tgtid     <= 1'b0;
            tgtid_err_cnt <= 8'd0;
        end else begin
            if (overflow) begin
                err_overflow <= 1'b1;
            end
            if (pend_miss) begin
                err_pend <= 1'b1;
            end
            if (tgt_bad) begin
                err_tgtid <= 1'b1;
                if (tgtid_err_cnt != 8'hFF) begin
                    tgtid_err_cnt <= tgtid_err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hnf_rxreq_ingress.sv
// tb_hnf_rxreq_ingress: directed scenarios plus a randomized run against a queue-based model.
// A second instance with DEPTH=16 covers the MAX_CREDITS ceiling.
module tb_hnf_rxreq_ingress;

    localparam int FLIT_W      = 64;
    localparam int DEPTH       = 8;
    localparam int MAX_CREDITS = 15;
    localparam int TGTID_LSB   = 4;
    localparam int TGTID_W     = 7;
    localparam int HN_ID       = 0;

    logic              clock = 1'b0;
    logic              rst_n = 1'b0;
    logic              link_en = 1'b0;
    logic              rxreqflitpend = 1'b0;
    logic              rxreqflitv = 1'b0;
    logic [FLIT_W-1:0] rxreqflit = '0;
    logic              out_ready = 1'b0;
    logic              err_clr = 1'b0;
    logic              rxreqlcrdv;
    logic [FLIT_W-1:0] out_flit;
    logic              out_valid;
    logic [3:0]        occupancy;
    logic [3:0]        credits_out;
    logic              link_idle;
    logic              err_overflow;
    logic              err_pend;
    logic              err_tgtid;
    logic [7:0]        tgtid_err_cnt;

    logic              link_en16 = 1'b0;
    logic              lcrdv16;
    logic [FLIT_W-1:0] out_flit16;
    logic              out_valid16;
    logic [4:0]        occupancy16;
    logic [3:0]        credits16;
    logic              link_idle16;
    logic              err_overflow16;
    logic              err_pend16;
    logic              err_tgtid16;
    logic [7:0]        tgtid_err_cnt16;

    int errors = 0;
    int checks = 0;

    logic [FLIT_W-1:0] sent_q [$];

    // Reference model state: credit count, a queue of accepted flits, sticky flags.
    int                m_credits = 0;
    logic [FLIT_W-1:0] m_q [$];
    bit                m_lcrdv = 1'b0;
    bit                m_pend = 1'b0;
    bit                m_eo = 1'b0;
    bit                m_ep = 1'b0;
    bit                m_et = 1'b0;
    int                m_cnt = 0;

    hnf_rxreq_ingress #(
        .FLIT_W(FLIT_W), .DEPTH(DEPTH), .MAX_CREDITS(MAX_CREDITS),
        .TGTID_LSB(TGTID_LSB), .TGTID_W(TGTID_W), .HN_ID(HN_ID)
    ) dut (
        .clock(clock), .rst_n(rst_n), .link_en(link_en),
        .rxreqflitpend(rxreqflitpend), .rxreqflitv(rxreqflitv), .rxreqflit(rxreqflit),
        .rxreqlcrdv(rxreqlcrdv), .out_flit(out_flit), .out_valid(out_valid),
        .out_ready(out_ready), .occupancy(occupancy), .credits_out(credits_out),
        .link_idle(link_idle), .err_clr(err_clr), .err_overflow(err_overflow),
        .err_pend(err_pend), .err_tgtid(err_tgtid), .tgtid_err_cnt(tgtid_err_cnt)
    );

    hnf_rxreq_ingress #(
        .FLIT_W(FLIT_W), .DEPTH(16), .MAX_CREDITS(MAX_CREDITS),
        .TGTID_LSB(TGTID_LSB), .TGTID_W(TGTID_W), .HN_ID(HN_ID)
    ) dut16 (
        .clock(clock), .rst_n(rst_n), .link_en(link_en16),
        .rxreqflitpend(1'b0), .rxreqflitv(1'b0), .rxreqflit('0),
        .rxreqlcrdv(lcrdv16), .out_flit(out_flit16), .out_valid(out_valid16),
        .out_ready(1'b0), .occupancy(occupancy16), .credits_out(credits16),
        .link_idle(link_idle16), .err_clr(1'b0), .err_overflow(err_overflow16),
        .err_pend(err_pend16), .err_tgtid(err_tgtid16), .tgtid_err_cnt(tgtid_err_cnt16)
    );

    always #5 clock = ~clock;

    function automatic logic [FLIT_W-1:0] make_flit(input logic [TGTID_W-1:0] tgt);
        logic [FLIT_W-1:0] f;
        f = {$urandom, $urandom};
        f[TGTID_LSB +: TGTID_W] = tgt;
        return f;
    endfunction

    function automatic logic [TGTID_W-1:0] bad_tgt();
        return TGTID_W'($urandom_range(1, (1 << TGTID_W) - 1));
    endfunction

    function automatic void model_reset();
        m_credits = 0;
        m_q.delete();
        m_lcrdv = 1'b0;
        m_pend  = 1'b0;
        m_eo    = 1'b0;
        m_ep    = 1'b0;
        m_et    = 1'b0;
        m_cnt   = 0;
    endfunction

    function automatic void model_step();
        bit has_credit, good, popped, granted;
        int c;
        has_credit = (m_credits > 0);
        good       = (rxreqflit[TGTID_LSB +: TGTID_W] == TGTID_W'(HN_ID));
        popped     = (m_q.size() > 0) && out_ready;
        if (err_clr) begin
            m_eo = 1'b0; m_ep = 1'b0; m_et = 1'b0; m_cnt = 0;
        end else begin
            if (rxreqflitv && !has_credit) m_eo = 1'b1;
            if (rxreqflitv && !m_pend) m_ep = 1'b1;
            if (rxreqflitv && has_credit && !good) begin
                m_et = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        if (popped) void'(m_q.pop_front());
        if (rxreqflitv && has_credit && good) m_q.push_back(rxreqflit);
        c = m_credits - ((rxreqflitv && has_credit) ? 1 : 0);
        granted = link_en && (c < MAX_CREDITS) && (c + m_q.size() < DEPTH);
        m_credits = c + (granted ? 1 : 0);
        m_lcrdv = granted;
        m_pend = rxreqflitpend;
    endfunction

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic test_reset();
        rst_n = 1'b0; link_en = 1'b1; link_en16 = 1'b1; rxreqflitpend = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({rxreqlcrdv, out_valid, out_flit, occupancy, credits_out, link_idle, err_overflow,
             err_pend, err_tgtid, tgtid_err_cnt} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%h exp=0", {rxreqlcrdv, out_valid, out_flit, occupancy,
                     credits_out, link_idle, err_overflow, err_pend, err_tgtid, tgtid_err_cnt});
        end
        checks++;
        if ({lcrdv16, out_valid16, occupancy16, credits16, err_tgtid16, tgtid_err_cnt16} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs16 got=%h exp=0",
                     {lcrdv16, out_valid16, occupancy16, credits16, err_tgtid16, tgtid_err_cnt16});
        end
    endtask

    task automatic test_initial_grants();
        int highs = 0, highs16 = 0, first = -1, last = -1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rxreqlcrdv) begin
                highs++;
                if (first < 0) first = i;
                last = i;
            end
            if (lcrdv16) highs16++;
        end
        checks++;
        if (highs !== 8 || (last - first) !== 7) begin
            errors++;
            $display("[TB] FAIL init_grants got=%0d span=%0d exp=8 span=7", highs, last - first);
        end
        checks++;
        if (credits_out !== 4'd8) begin
            errors++; $display("[TB] FAIL init_credits got=%0d exp=8", credits_out);
        end
        checks++;
        if (highs16 !== 15 || credits16 !== 4'd15 || lcrdv16 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL depth16_grants got=%0d credits=%0d exp=15 credits=15", highs16, credits16);
        end
    endtask

    task automatic test_fill_and_pop();
        int grants = 0;
        bit pulse_now;
        sent_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rxreqflitv = 1'b1;
            rxreqflit = make_flit(TGTID_W'(HN_ID));
            sent_q.push_back(rxreqflit);
            @(negedge clock);
            grants += int'(rxreqlcrdv);
        end
        rxreqflitv = 1'b0;
        @(negedge clock);
        grants += int'(rxreqlcrdv);
        checks++;
        if (occupancy !== 4'd8 || credits_out !== 4'd0 || grants !== 0) begin
            errors++;
            $display("[TB] FAIL fill_state got occ=%0d cred=%0d grants=%0d exp occ=8 cred=0 grants=0",
                     occupancy, credits_out, grants);
        end
        checks++;
        if (out_flit !== sent_q[0]) begin
            errors++; $display("[TB] FAIL fill_head got=%h exp=%h", out_flit, sent_q[0]);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        pulse_now = rxreqlcrdv;
        grants = int'(rxreqlcrdv);
        repeat (3) begin
            @(negedge clock);
            grants += int'(rxreqlcrdv);
        end
        checks++;
        if (pulse_now !== 1'b1 || grants !== 1) begin
            errors++; $display("[TB] FAIL pop_regrant got first=%0b total=%0d exp first=1 total=1", pulse_now, grants);
        end
        checks++;
        if (occupancy !== 4'd7 || credits_out !== 4'd1 || out_flit !== sent_q[1]) begin
            errors++;
            $display("[TB] FAIL pop_state got occ=%0d cred=%0d head=%h exp occ=7 cred=1 head=%h",
                     occupancy, credits_out, out_flit, sent_q[1]);
        end
    endtask

    task automatic test_tgtid();
        int grants;
        rxreqflitv = 1'b1;
        rxreqflit = make_flit(TGTID_W'(5));
        @(negedge clock);
        rxreqflitv = 1'b0;
        grants = int'(rxreqlcrdv);
        checks++;
        if (occupancy !== 4'd7 || err_tgtid !== 1'b1 || tgtid_err_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL tgtid_single got occ=%0d flag=%0b cnt=%0d exp occ=7 flag=1 cnt=1",
                     occupancy, err_tgtid, tgtid_err_cnt);
        end
        repeat (3) begin
            @(negedge clock);
            grants += int'(rxreqlcrdv);
        end
        checks++;
        if (grants !== 1 || credits_out !== 4'd1) begin
            errors++; $display("[TB] FAIL tgtid_regrant got grants=%0d cred=%0d exp grants=1 cred=1", grants, credits_out);
        end
        for (int i = 0; i < 300; i++) begin
            rxreqflitv = 1'b1;
            rxreqflit = make_flit(bad_tgt());
            @(negedge clock);
        end
        rxreqflitv = 1'b0;
        @(negedge clock);
        checks++;
        if (tgtid_err_cnt !== 8'd255) begin
            errors++; $display("[TB] FAIL tgtid_saturate got=%0d exp=255", tgtid_err_cnt);
        end
        checks++;
        if (occupancy !== 4'd7 || credits_out !== 4'd1 || err_pend !== 1'b0 || err_overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tgtid_side_effects got occ=%0d cred=%0d pend=%0b ovf=%0b exp 7 1 0 0",
                     occupancy, credits_out, err_pend, err_overflow);
        end
    endtask

    task automatic test_error_flags();
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        checks++;
        if ({err_overflow, err_pend, err_tgtid, tgtid_err_cnt} !== '0) begin
            errors++; $display("[TB] FAIL err_clr_first got=%h exp=0", {err_overflow, err_pend, err_tgtid, tgtid_err_cnt});
        end
        err_clr = 1'b1;
        rxreqflitv = 1'b1;
        rxreqflit = make_flit(bad_tgt());
        @(negedge clock);
        err_clr = 1'b0;
        rxreqflitv = 1'b0;
        checks++;
        if (err_tgtid !== 1'b0 || tgtid_err_cnt !== 8'd0 || credits_out !== 4'd1) begin
            errors++;
            $display("[TB] FAIL clr_priority got flag=%0b cnt=%0d cred=%0d exp 0 0 1", err_tgtid, tgtid_err_cnt, credits_out);
        end
        rxreqflitv = 1'b1;
        rxreqflit = make_flit(TGTID_W'(HN_ID));
        @(negedge clock);
        rxreqflit = make_flit(TGTID_W'(HN_ID));
        @(negedge clock);
        rxreqflitv = 1'b0;
        checks++;
        if (err_overflow !== 1'b1 || occupancy !== 4'd8 || credits_out !== 4'd0 || out_flit !== sent_q[1]) begin
            errors++;
            $display("[TB] FAIL overflow got flag=%0b occ=%0d cred=%0d head=%h exp 1 8 0 %h",
                     err_overflow, occupancy, credits_out, out_flit, sent_q[1]);
        end
        out_ready = 1'b1;
        repeat (8) @(negedge clock);
        out_ready = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if (occupancy !== 4'd0 || credits_out !== 4'd8 || out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL drain got occ=%0d cred=%0d exp occ=0 cred=8", occupancy, credits_out);
        end
        rxreqflitpend = 1'b0;
        @(negedge clock);
        rxreqflitpend = 1'b1;
        rxreqflitv = 1'b1;
        rxreqflit = make_flit(TGTID_W'(HN_ID));
        sent_q.delete();
        sent_q.push_back(rxreqflit);
        @(negedge clock);
        rxreqflitv = 1'b0;
        checks++;
        if (err_pend !== 1'b1 || occupancy !== 4'd1 || out_flit !== sent_q[0] || err_overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pend_miss got pend=%0b occ=%0d ovf=%0b exp pend=1 occ=1 ovf=1", err_pend, occupancy, err_overflow);
        end
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        checks++;
        if ({err_overflow, err_pend, err_tgtid, tgtid_err_cnt} !== '0) begin
            errors++; $display("[TB] FAIL err_clr_all got=%h exp=0", {err_overflow, err_pend, err_tgtid, tgtid_err_cnt});
        end
    endtask

    task automatic test_link_down();
        int grants = 0;
        rst_n = 1'b0;
        link_en = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (link_idle !== 1'b1 || credits_out !== 4'd0) begin
            errors++; $display("[TB] FAIL idle_in_reset got idle=%0b cred=%0d exp idle=1 cred=0", link_idle, credits_out);
        end
        @(negedge clock);
        rst_n = 1'b1;
        link_en = 1'b1;
        repeat (3) @(negedge clock);
        link_en = 1'b0;
        @(negedge clock);
        checks++;
        if (credits_out !== 4'd3 || rxreqlcrdv !== 1'b0 || link_idle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL link_drop got cred=%0d lcrdv=%0b idle=%0b exp 3 0 0", credits_out, rxreqlcrdv, link_idle);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rxreqflitv = 1'b1;
            rxreqflit = make_flit(TGTID_W'(HN_ID));
            @(negedge clock);
            grants += int'(rxreqlcrdv);
            if (i == 1) begin
                checks++;
                if (link_idle !== 1'b0) begin
                    errors++; $display("[TB] FAIL idle_early got=%0b exp=0", link_idle);
                end
            end
        end
        rxreqflitv = 1'b0;
        checks++;
        if (link_idle !== 1'b1 || credits_out !== 4'd0 || grants !== 0) begin
            errors++;
            $display("[TB] FAIL link_idle got idle=%0b cred=%0d grants=%0d exp 1 0 0", link_idle, credits_out, grants);
        end
        link_en = 1'b1;
        @(negedge clock);
        checks++;
        if (rxreqlcrdv !== 1'b1 || link_idle !== 1'b0) begin
            errors++; $display("[TB] FAIL link_resume got lcrdv=%0b idle=%0b exp 1 0", rxreqlcrdv, link_idle);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            rxreqflitv = 1'b1;
            rxreqflit = make_flit((i == 2) ? bad_tgt() : TGTID_W'(HN_ID));
            @(negedge clock);
        end
        rxreqflitv = 1'b0;
        checks++;
        if (occupancy !== 4'd2 || err_tgtid !== 1'b1) begin
            errors++; $display("[TB] FAIL pre_reset got occ=%0d tgt=%0b exp occ=2 tgt=1", occupancy, err_tgtid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rxreqlcrdv, out_valid, out_flit, occupancy, credits_out, link_idle, err_overflow,
             err_pend, err_tgtid, tgtid_err_cnt} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset got=%h exp=0", {rxreqlcrdv, out_valid, out_flit, occupancy,
                     credits_out, link_idle, err_overflow, err_pend, err_tgtid, tgtid_err_cnt});
        end
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [FLIT_W-1:0] exp_flit;
        for (int i = 0; i < 3000; i++) begin
            link_en = ($urandom_range(0, 9) != 0);
            out_ready = 1'($urandom_range(0, 1));
            rxreqflitpend = ($urandom_range(0, 7) != 0);
            err_clr = ($urandom_range(0, 199) == 0);
            rxreqflitv = ($urandom_range(0, 2) != 0) && ((m_credits > 0) || ($urandom_range(0, 19) == 0));
            rxreqflit = make_flit(($urandom_range(0, 9) == 0) ? bad_tgt() : TGTID_W'(HN_ID));
            @(negedge clock);
            exp_flit = (m_q.size() > 0) ? m_q[0] : '0;
            checks++;
            if (rxreqlcrdv !== m_lcrdv || credits_out !== 4'(m_credits)) begin
                errors++;
                $display("[TB] FAIL rand_credit cyc=%0d got lcrdv=%0b cred=%0d exp lcrdv=%0b cred=%0d",
                         i, rxreqlcrdv, credits_out, m_lcrdv, m_credits);
            end
            checks++;
            if (occupancy !== 4'(m_q.size()) || out_valid !== (m_q.size() > 0) || out_flit !== exp_flit) begin
                errors++;
                $display("[TB] FAIL rand_queue cyc=%0d got occ=%0d head=%h exp occ=%0d head=%h",
                         i, occupancy, out_flit, m_q.size(), exp_flit);
            end
            checks++;
            if ({err_overflow, err_pend, err_tgtid} !== {m_eo, m_ep, m_et} || tgtid_err_cnt !== 8'(m_cnt)
                || link_idle !== (!link_en && m_credits == 0)) begin
                errors++;
                $display("[TB] FAIL rand_errors cyc=%0d got flags=%b cnt=%0d idle=%0b exp flags=%b cnt=%0d",
                         i, {err_overflow, err_pend, err_tgtid}, tgtid_err_cnt, link_idle, {m_eo, m_ep, m_et}, m_cnt);
            end
        end
        err_clr = 1'b0;
        rxreqflitv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_initial_grants();
        test_fill_and_pop();
        test_tgtid();
        test_error_flags();
        test_link_down();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
